// File: rtl/vga_scanout.sv
// VGA scanout: word FIFO fed by the fetch stage, 640x480@60 timing from a
// pixel-enable divider, and RGB332 unpacking of four pixels per 32-bit word.
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [31:0]                   pix_dat_i,
    input  logic                          pix_wr_i,
    output logic                          fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          frame_start_o,
    output logic                          underflow_o,
    output logic                          vga_hs_o,
    output logic                          vga_vs_o,
    output logic [2:0]                    vga_r_o,
    output logic [2:0]                    vga_g_o,
    output logic [1:0]                    vga_b_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          pix_en;
    logic          active;
    logic          frame_sync;
    logic          pop_slot;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic [31:0]   head;
    logic          fifo_empty;
    logic          flush;
    logic          do_push;
    logic          do_pop;

    logic [31:0]   shreg;
    rgb332_t       pix_q;

    // Raster position decode; everything below acts on pre-increment counts.
    assign pix_en     = (cnt == CNT_LAST);
    assign active     = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign frame_sync = (vcnt == V_ACT) && (hcnt == '0);
    assign pop_slot   = pix_en && active && (hcnt[1:0] == 2'b00);

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_level_o == '0);
    assign flush      = pix_en && frame_sync;
    // Fullness is the registered flag, so a pop in the same cycle cannot admit a push.
    assign do_push    = pix_wr_i && !fifo_full_o && !flush;
    assign do_pop     = pop_slot && !fifo_empty;

    always_comb begin
        level_nxt = fifo_level_o + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            cnt <= pix_en ? '0 : cnt + 1'b1;
            if (pix_en) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push)
            mem[wr_ptr] <= pix_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            fifo_full_o  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level_o <= level_nxt;
            fifo_full_o  <= (level_nxt == DEPTH_L);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vga_hs_o      <= 1'b1;
            vga_vs_o      <= 1'b1;
            pix_q         <= '0;
            shreg         <= '0;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            if (pix_en) begin
                vga_hs_o <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
                vga_vs_o <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
                if (active) begin
                    if (hcnt[1:0] == 2'b00) begin
                        // An empty FIFO blanks the whole 4-pixel group.
                        if (!fifo_empty) begin
                            pix_q <= rgb332_t'(head[7:0]);
                            shreg <= head >> 8;
                        end else begin
                            pix_q       <= '0;
                            shreg       <= '0;
                            underflow_o <= 1'b1;
                        end
                    end else begin
                        pix_q <= rgb332_t'(shreg[7:0]);
                        shreg <= shreg >> 8;
                    end
                end else begin
                    pix_q <= '0;
                end
                if (frame_sync) begin
                    frame_start_o <= 1'b1;
                    underflow_o   <= 1'b0;
                end
            end
        end
    end

    assign vga_r_o = pix_q.r;
    assign vga_g_o = pix_q.g;
    assign vga_b_o = pix_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster: queue-based reference model
// compared every clock, plus directed literal checks and randomized feeding.
module tb_vga_scanout;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 3;
    localparam int DIV = 4, DEPTH = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * DIV;
    localparam int BLANK_TO_ACTIVE = (VT - VA) * HT * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dat;
    logic        wr;
    logic        full, fs, uf, hs, vs;
    logic [4:0]  level;
    logic [2:0]  r, g;
    logic [1:0]  b;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .pix_dat_i(dat), .pix_wr_i(wr),
        .fifo_full_o(full), .fifo_level_o(level), .frame_start_o(fs),
        .underflow_o(uf), .vga_hs_o(hs), .vga_vs_o(vs),
        .vga_r_o(r), .vga_g_o(g), .vga_b_o(b)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rgb(input string name, input int er, input int eg, input int eb);
        chk({name, "_r"}, r, er);
        chk({name, "_g"}, g, eg);
        chk({name, "_b"}, b, eb);
    endtask

    // Reference model: raster position from elapsed clocks, FIFO as a queue.
    int          m_cnt;
    logic [31:0] q[$];
    logic [31:0] cur;
    bit          cur_ok;
    bit          e_hs, e_vs, e_fs, e_uf;
    logic [7:0]  e_pix;
    bit          tick, push_ok;
    int          p, h, v;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; q.delete(); cur_ok = 0;
            e_hs = 1; e_vs = 1; e_fs = 0; e_uf = 0; e_pix = 8'h00;
        end else begin
            tick = (m_cnt % DIV) == DIV - 1;
            p = m_cnt / DIV;
            h = p % HT;
            v = (p / HT) % VT;
            m_cnt++;
            push_ok = wr && (q.size() < DEPTH);
            e_fs = 0;
            if (tick) begin
                e_hs = !(h >= HA + HF && h < HA + HF + HS);
                e_vs = !(v >= VA + VF && v < VA + VF + VS);
                if (v == VA && h == 0) begin
                    q.delete(); e_fs = 1; e_uf = 0; push_ok = 0;
                end
                if (h < HA && v < VA) begin
                    if (h % 4 == 0) begin
                        if (q.size() > 0) begin cur = q.pop_front(); cur_ok = 1; end
                        else begin cur_ok = 0; e_uf = 1; end
                    end
                    e_pix = cur_ok ? cur[8*(h%4) +: 8] : 8'h00;
                end else begin
                    e_pix = 8'h00;
                end
            end
            if (push_ok) q.push_back(dat);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hs", hs, e_hs);
            chk("vs", vs, e_vs);
            chk("pix", {r, g, b}, e_pix);
            chk("frame_start", fs, e_fs);
            chk("underflow", uf, e_uf);
            chk("level", level, q.size());
            chk("full", full, q.size() == DEPTH);
        end
    end

    // Sync timing measurements, judged once at the end of the run.
    int  cyc = 0;
    bit  hs_p = 1, vs_p = 1;
    int  hs_fall = -1, vs_fall = -1, fs_cyc = -1;
    int  hs_low = -1, hs_per = -1, hs_off = -1, vs_low = -1, fs_per = -1;
    bit  fs_p = 0, fs_wide = 0;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            if (hs_p && !hs) begin
                if (hs_fall >= 0) hs_per = cyc - hs_fall;
                if (fs_cyc >= 0) hs_off = (cyc - fs_cyc) % (HT * DIV);
                hs_fall = cyc;
            end
            if (!hs_p && hs && hs_fall >= 0) hs_low = cyc - hs_fall;
            if (vs_p && !vs) vs_fall = cyc;
            if (!vs_p && vs && vs_fall >= 0) vs_low = cyc - vs_fall;
            if (fs) begin
                if (fs_cyc >= 0) fs_per = cyc - fs_cyc;
                fs_cyc = cyc;
                if (fs_p) fs_wide = 1;
            end
        end
        hs_p = hs; vs_p = vs; fs_p = fs;
    end

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs && n < 2 * FRAME);
        chk("wait_frame_start", fs, 1);
    endtask

    initial begin
        int pct;
        rst = 1; wr = 0; dat = '0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk_rgb("rst", 0, 0, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_uf", uf, 0);
        rst = 0;

        // First pix_en lands on the 4th clock: the first pop finds the FIFO empty.
        repeat (3) @(negedge clk);
        chk("uf_before_first_tick", uf, 0);
        @(negedge clk);
        chk("uf_at_first_tick", uf, 1);

        // Unpack a single word, then underflow on the next group.
        wait_fs();
        chk("fs_level", level, 0);
        wr = 1; dat = 32'h03E01CFF;
        @(negedge clk);
        wr = 0;
        repeat (BLANK_TO_ACTIVE - 1) @(negedge clk);
        chk_rgb("px0", 7, 7, 3);
        chk("px0_uf", uf, 0);
        repeat (4) @(negedge clk);
        chk_rgb("px1", 0, 7, 0);
        repeat (4) @(negedge clk);
        chk_rgb("px2", 7, 0, 0);
        repeat (4) @(negedge clk);
        chk_rgb("px3", 0, 0, 3);
        repeat (4) @(negedge clk);
        chk_rgb("px4", 0, 0, 0);
        chk("px4_uf", uf, 1);

        // Overfill during blanking: words 17..20 dropped.
        wait_fs();
        for (int i = 1; i <= 20; i++) begin
            wr = 1; dat = {4{8'(i)}};
            @(negedge clk);
        end
        wr = 0;
        chk("sat_level", level, 16);
        chk("sat_full", full, 1);
        repeat (BLANK_TO_ACTIVE - 20) @(negedge clk);
        chk("word1_px", {r, g, b}, 1);
        chk("word1_uf", uf, 0);
        repeat (16) @(negedge clk);
        chk("word2_px", {r, g, b}, 2);

        // Mid-frame reset with the FIFO half full (two lines popped 8 words).
        repeat (2 * HT * DIV - 24) @(negedge clk);
        chk("pre_rst_level", level, 8);
        rst = 1;
        @(negedge clk);
        chk("midrst_level", level, 0);
        chk("midrst_hs", hs, 1);
        chk("midrst_vs", vs, 1);
        chk_rgb("midrst", 0, 0, 0);
        rst = 0;

        // Randomized feeding, feed intensity changing per frame.
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 5))
                0: pct = 0;
                1: pct = 5;
                2: pct = 10;
                3: pct = 20;
                4: pct = 50;
                default: pct = 100;
            endcase
            for (int c = 0; c < FRAME; c++) begin
                wr  = ($urandom_range(0, 99) < pct);
                dat = $urandom;
                @(negedge clk);
            end
        end
        wr = 0;

        chk("hs_low_clks", hs_low, HS * DIV);
        chk("hs_fall_offset", hs_off, (HA + HF) * DIV);
        chk("line_period", hs_per, HT * DIV);
        chk("vs_low_clks", vs_low, VS * HT * DIV);
        chk("frame_period", fs_per, FRAME);
        chk("fs_one_clock", fs_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Downstream consumer of the video-memory fetch stage. Accepts 32-bit framebuffer words pushed by the Wishbone fetch master into an internal FIFO. Generates 640x480@60 VGA timing from the system clock via a pixel-enable divider. Unpacks each word into four RGB332 pixels for the Nexys3 VGA pins. Signals the fetch stage when to restart at the frame base and flags FIFO underflow.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)
- FIFO_DEPTH, 16, word FIFO depth, power of two >= 4
- wb_clk_i  in  1  system clock, only clock in block
- wb_rst_i  in  1  synchronous, active-high reset
- pix_dat_i  in  32  framebuffer word from fetch stage
- pix_wr_i  in  1  push strobe, one word per asserted cycle
- fifo_full_o  out  1  FIFO full; pushes are dropped while high
- fifo_level_o  out  log2(FIFO_DEPTH)+1  words currently held
- frame_start_o  out  1  one-clock pulse: fetch stage restarts at frame base
- underflow_o  out  1  sticky: a pop found the FIFO empty this frame
- vga_hs_o  out  1  horizontal sync, active low
- vga_vs_o  out  1  vertical sync, active low
- vga_r_o  out  3  red
- vga_g_o  out  3  green
- vga_b_o  out  2  blue

## Operation
- Divider cnt 0..CLK_DIV-1; pix_en is high for one clock when cnt==CLK_DIV-1.
- On pix_en: hcnt advances 0..H_TOT-1 (H_TOT=800). At wrap, hcnt returns to 0 and vcnt advances 0..V_TOT-1 (V_TOT=525), then wraps to 0.
- active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- hsync asserted (low) for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- vsync asserted (low) for vcnt in [V_ACTIVE+V_FP, +V_SYNC), i.e. 490..491.
- Pixel format: byte = {R[2:0],G[2:0],B[1:0]}. Byte 0 (bits 7:0) is displayed first, then bytes 1, 2, 3.
- Pop rule: on pix_en with active and hcnt[1:0]==0, pop the FIFO head (show-ahead, mem[rd_ptr]) into a 32-bit shift register and display byte 0. The next three pix_en ticks display bytes 1..3 by shifting right 8.
- Underflow: if the FIFO is empty at a pop tick, do not pop, display black for that 4-pixel group, and set underflow_o.
- Blanking (!active): rgb outputs forced to 0.
- FIFO push: accepted iff pix_wr_i && !fifo_full_o. Fullness is sampled before any same-cycle pop, so a push while full is dropped even when a pop occurs that cycle.
- Simultaneous push+pop when not full: level unchanged.
- Frame sync: on pix_en with vcnt==V_ACTIVE && hcnt==0 (start of vertical blank):
  - frame_start_o pulses for one clock.
  - FIFO is flushed (pointers and level to 0); a push in that same clock is dropped.
  - underflow_o clears.
- Fetch stage refills the FIFO during the 45 blank lines.

## Timing
- All outputs are registered. Reset values: vga_hs_o=1, vga_vs_o=1, rgb=0, frame_start_o=0, underflow_o=0, fifo_full_o=0, fifo_level_o=0.
- Reset also clears cnt, hcnt, vcnt, FIFO pointers and the shift register.
- Reset mid-frame discards FIFO contents and restarts at hcnt=vcnt=0 on the next clock; the first pix_en comes CLK_DIV clocks after reset deasserts.
- Output latency: VGA pins update on the clock edge where pix_en is high, using the hcnt/vcnt values before that edge's increment. Pins are held for CLK_DIV clocks.
- fifo_level_o and fifo_full_o update on the clock after a push or pop.
- Line period is H_TOT*CLK_DIV = 3200 clocks. Frame period is 3200*525 = 1,680,000 clocks.
- A line consumes 160 words; the FIFO must never be popped more than once per 4 pix_en ticks.

## Test plan
- Reset: hold wb_rst_i 3 clocks -> hs=vs=1, rgb=0, level=0, full=0, underflow=0; first pix_en arrives 4 clocks after release.
- Line timing: free-run one line -> vga_hs_o low for exactly 384 clocks, falling 2624 clocks after line start; line period 3200 clocks.
- Frame timing: free-run one frame -> vga_vs_o low for 6400 clocks; frame_start_o one-clock pulse every 1,680,000 clocks, coinciding with the FIFO level dropping to 0.
- Unpack: after frame_start, push 0x03E01CFF then idle -> first four active pixels show RGB (7,7,3), (0,7,0), (7,0,0), (0,0,3); following group is black with underflow_o=1 until the next frame_start.
- Full/drop: push 20 words back-to-back during blanking -> level saturates at 16, fifo_full_o=1, words 17..20 dropped; the first active line shows words 1..16 in order.
- Mid-frame reset: assert wb_rst_i at vcnt=100 with FIFO half full -> next clock level=0, hs=vs=1, rgb=0; counting restarts from 0.
